// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clk_gen
// Purpose  : I2S/TDM clock and framing generator. Derives SCKI, BCK and
//            LRCK/frame-sync from mck and emits bit/slot indices plus BCK
//            edge strobes for the serializer/deserializer. Runtime config
//            (BCK ratio, slot width, slot count, frame format) is taken via a
//            level req / pulse ack handshake and applied on a frame boundary.
// Ports    : mck, rst (async, active-high), en (sync run enable)
//            cfg_req/cfg_ack handshake, cfg_bck_div, cfg_slot_bits,
//            cfg_num_slots, cfg_mode (0=I2S, 1=LJ, 2=TDM LJ, 3=TDM I2S)
//            scki, bck, lrck, bit_idx, slot_idx, bck_fall, bck_rise,
//            frame_start
// Revision : 1.0 - initial release
// ============================================================================
module i2s_clk_gen #(
  parameter int SCKI_DIV      = 2,
  parameter int DIV_W         = 4,
  parameter int BIT_W         = 6,
  parameter int SLOT_W        = 4,
  parameter int DEF_BCK_DIV   = 1,
  parameter int DEF_SLOT_BITS = 31,
  parameter int DEF_NUM_SLOTS = 1,
  parameter int DEF_MODE      = 0
) (
  input  logic              mck,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_req,
  input  logic [DIV_W-1:0]  cfg_bck_div,
  input  logic [BIT_W-1:0]  cfg_slot_bits,
  input  logic [SLOT_W-1:0] cfg_num_slots,
  input  logic [1:0]        cfg_mode,
  output logic              cfg_ack,
  output logic              scki,
  output logic              bck,
  output logic              lrck,
  output logic [BIT_W-1:0]  bit_idx,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              bck_fall,
  output logic              bck_rise,
  output logic              frame_start
);

  localparam int SC_HALF = SCKI_DIV / 2;
  // Keep the SCKI counter at least one bit wide even when it never counts.
  localparam int SC_W = (SC_HALF > 1) ? $clog2(SC_HALF) : 1;
  localparam logic [SC_W-1:0] C_SC_TERM = SC_W'(SC_HALF - 1);

  localparam logic [1:0] C_MODE_I2S     = 2'd0;
  localparam logic [1:0] C_MODE_LJ      = 2'd1;
  localparam logic [1:0] C_MODE_TDM_LJ  = 2'd2;

  // Active configuration
  logic [DIV_W-1:0]  r_bck_div_a;
  logic [BIT_W-1:0]  r_slot_bits_a;
  logic [SLOT_W-1:0] r_num_slots_a;
  logic [1:0]        r_mode_a;

  logic [SC_W-1:0]   r_scnt;
  logic [DIV_W-1:0]  r_dcnt;

  logic              w_bck_term;
  logic              w_fall;
  logic              w_rise;
  logic              w_bit_wrap;
  logic              w_slot_wrap;
  logic              w_frame;
  logic              w_apply;
  logic              w_lrck_nxt;
  logic              w_lrck_idle;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [SLOT_W-1:0] w_slot_after;
  logic [SLOT_W:0]   w_half;

  always_comb begin
    w_bck_term  = (r_dcnt == r_bck_div_a);
    w_fall      = w_bck_term & bck;
    w_rise      = w_bck_term & ~bck;
    w_bit_wrap  = (bit_idx == r_slot_bits_a);
    w_slot_wrap = (slot_idx == r_num_slots_a);
    w_bit_nxt   = w_bit_wrap ? '0 : bit_idx + 1'b1;
    w_slot_nxt  = slot_idx;
    if (w_bit_wrap) begin
      w_slot_nxt = w_slot_wrap ? '0 : slot_idx + 1'b1;
    end
    // Slot that follows the one being entered; I2S switches lrck for it
    // one bit early.
    w_slot_after = (w_slot_nxt == r_num_slots_a) ? '0 : w_slot_nxt + 1'b1;
    w_frame      = w_fall & w_bit_wrap & w_slot_wrap;
    w_half       = ({1'b0, r_num_slots_a} + 1'b1) >> 1;
    // While idle, I2S lrck rests at the level it has for slot 0.
    w_lrck_idle  = (r_mode_a == C_MODE_I2S) && (w_half == '0);

    w_lrck_nxt = lrck;
    case (r_mode_a)
      C_MODE_I2S: begin
        if (w_bit_nxt == r_slot_bits_a) begin
          w_lrck_nxt = ({1'b0, w_slot_after} >= w_half);
        end
      end
      C_MODE_LJ: begin
        if (w_bit_wrap) begin
          w_lrck_nxt = ({1'b0, w_slot_nxt} >= w_half);
        end
      end
      C_MODE_TDM_LJ: begin
        w_lrck_nxt = (w_bit_nxt == '0) && (w_slot_nxt == '0);
      end
      default: begin
        w_lrck_nxt = (w_bit_nxt == r_slot_bits_a) && (w_slot_nxt == r_num_slots_a);
      end
    endcase

    // Stopped: apply immediately. Running: only on the frame boundary so
    // the frame in progress completes at the old rate.
    w_apply = cfg_req & (~en | w_frame);
  end

  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      r_bck_div_a   <= DIV_W'(DEF_BCK_DIV);
      r_slot_bits_a <= BIT_W'(DEF_SLOT_BITS);
      r_num_slots_a <= SLOT_W'(DEF_NUM_SLOTS);
      r_mode_a      <= 2'(DEF_MODE);
      r_scnt        <= '0;
      r_dcnt        <= '0;
      cfg_ack       <= 1'b0;
      scki          <= 1'b0;
      bck           <= 1'b0;
      lrck          <= 1'b0;
      bit_idx       <= '0;
      slot_idx      <= '0;
      bck_fall      <= 1'b0;
      bck_rise      <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      cfg_ack <= w_apply;
      if (w_apply) begin
        r_bck_div_a   <= cfg_bck_div;
        r_slot_bits_a <= cfg_slot_bits;
        r_num_slots_a <= cfg_num_slots;
        r_mode_a      <= cfg_mode;
      end

      if (!en) begin
        r_scnt      <= '0;
        r_dcnt      <= '0;
        scki        <= 1'b0;
        bck         <= 1'b0;
        lrck        <= w_lrck_idle;
        bit_idx     <= '0;
        slot_idx    <= '0;
        bck_fall    <= 1'b0;
        bck_rise    <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        if (r_scnt == C_SC_TERM) begin
          r_scnt <= '0;
          scki   <= ~scki;
        end else begin
          r_scnt <= r_scnt + 1'b1;
        end

        if (w_bck_term) begin
          r_dcnt <= '0;
          bck    <= ~bck;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end

        bck_fall    <= w_fall;
        bck_rise    <= w_rise;
        frame_start <= w_frame;

        if (w_fall) begin
          bit_idx  <= w_bit_nxt;
          slot_idx <= w_slot_nxt;
          lrck     <= w_lrck_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/i2s_clk_gen.md
Name: i2s_clk_gen

Overview:
- Parametrised I2S/TDM clock and framing generator; next generation of the pedal's fixed-ratio codec clock divider.
- Derives SCKI, BCK and LRCK/frame-sync from the master clock `mck`.
- BCK ratio, slot width, slot count and frame format are configured at runtime.
- Emits bit/slot indices and edge strobes for the serializer/deserializer.
- Config changes are accepted through a req/ack handshake and applied only on a frame boundary, so the codec never sees a glitch.

Parameters:
- SCKI_DIV, 2, mck cycles per SCKI period; even, ≥2.
- DIV_W, 4, width of bck_div.
- BIT_W, 6, width of slot_bits and bit_idx.
- SLOT_W, 4, width of num_slots and slot_idx.
- DEF_BCK_DIV, 1, reset value of the active bck_div.
- DEF_SLOT_BITS, 31, reset value of the active slot_bits.
- DEF_NUM_SLOTS, 1, reset value of the active num_slots.
- DEF_MODE, 0, reset value of the active mode.

Ports:
- mck  in  1  master clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable, synchronous.
- cfg_req  in  1  level request; config fields must stay stable while it is high.
- cfg_bck_div  in  DIV_W  BCK half-period in mck cycles, minus 1.
- cfg_slot_bits  in  BIT_W  bits per slot, minus 1.
- cfg_num_slots  in  SLOT_W  slots per frame, minus 1.
- cfg_mode  in  2  frame format: 0=I2S, 1=left-justified, 2=TDM pulse (LJ-aligned), 3=TDM pulse (I2S-aligned).
- cfg_ack  out  1  one-cycle pulse when the new config is applied.
- scki  out  1  system clock to the codec.
- bck  out  1  bit clock.
- lrck  out  1  word select / frame sync.
- bit_idx  out  BIT_W  current bit within the slot; 0 = MSB.
- slot_idx  out  SLOT_W  current slot.
- bck_fall  out  1  high in the cycle bck becomes 0; transmit shift strobe.
- bck_rise  out  1  high in the cycle bck becomes 1; receive sample strobe.
- frame_start  out  1  high in the cycle bit_idx and slot_idx both wrap to 0.

Behaviour:
- **Reset (rst=1, asynchronous):**
  - All outputs and counters are 0.
  - Active config is loaded from the DEF_* parameters.
  - Any pending cfg_req is forgotten.
- **Enable (en=0):**
  - Next edge: counters are cleared; scki, bck, lrck (mode 0: value for slot 0), the strobes and frame_start go to 0.
  - On the first edge with en=1, counting starts from bit 0, slot 0.
- **scki:**
  - A free counter 0..SCKI_DIV/2-1 toggles scki at the terminal count.
  - Runs only while en=1.
- **bck:**
  - dcnt counts 0..bck_div_a (the active bck_div); bck toggles at the terminal count.
  - The first rise is bck_div_a+1 cycles after en goes high.
  - BCK period = 2·(bck_div_a+1) mck cycles.
- **Indices:**
  - bit_idx advances on each bck_fall, wrapping after slot_bits_a.
  - On that wrap slot_idx advances, wrapping after num_slots_a.
  - The double wrap asserts frame_start, in the same cycle as bck_fall.
  - The first frame after en does not assert frame_start; bit/slot start at 0.
- **lrck by mode** (half = (num_slots_a+1)>>1):
  - Mode 1: lrck=1 while slot_idx ≥ half; it changes in the frame_start/slot-wrap cycle.
  - Mode 0: same as mode 1, but each transition is one BCK early, in the bck_fall where bit_idx becomes slot_bits_a of the preceding slot.
  - Mode 2: lrck=1 for exactly one BCK period, while slot 0 / bit 0.
  - Mode 3: lrck=1 for exactly one BCK period, while last slot / last bit.
- **Config handshake:**
  - With cfg_req=1 and en=1, the fields are captured into the active config in the frame_start cycle.
  - cfg_ack pulses that same cycle; new values govern from the next cycle.
  - The frame in progress finishes at the old rate.
  - With en=0, the config is applied on the next edge and cfg_ack pulses then.
  - Requester drops cfg_req after ack; req held high re-applies the same values every frame (harmless).
  - Simultaneous cfg_req rise and frame_start: the config is applied in that cycle.
- **Counter widths:** all counters are unsigned and wrap only at the active terminal values; no overflow path exists.

Test Plan:
- **Defaults:** rst pulse, en=1.
  - bck period 4 mck; scki period 2.
  - frame_start every 256 mck; bit_idx 0..31, slot_idx 0..1.
  - Mode 0: lrck falls 4 mck before frame_start.
- **Left-justified:** cfg_mode=1 via handshake.
  - cfg_ack coincides with frame_start.
  - lrck edges coincide with frame_start and the slot-1 wrap.
  - lrck high 128 mck per frame.
- **TDM:** cfg_bck_div=0, slot_bits=15, num_slots=7, mode=2.
  - bck period 2; frame = 256 mck.
  - lrck high for exactly 2 mck, in the frame_start cycle.
  - slot_idx steps 0..7.
- **Mid-frame reconfiguration:** cfg_req mid-frame, bck_div 1→3.
  - Remainder of the frame keeps period 4; ack at the boundary.
  - Next frame has bck period 8 and length 512 mck.
- **Enable drop:** en=0 at slot 1, bit 10.
  - Next edge: bck=scki=0, indices 0.
  - en=1 again: first bck rise after 2 mck; the first full frame is identical to the defaults case.
- **Async reset:** rst asserted mid-frame with cfg_req high.
  - Outputs go to 0 without waiting for a clock edge.
  - Defaults restored; no cfg_ack until a new frame_start with req high.
